// File: rtl/regfile_write_bank_if.sv
// regfile_write_bank_if: write port and register-state bus of the general-purpose register file
interface regfile_write_bank_if #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32,
  parameter int AW = 5
);
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NREGS-1:0][WIDTH-1:0] regs_out;
  logic [NREGS-1:0] wr_onehot;
  logic [15:0] write_count;
  modport master (output wr_en, wr_addr, wr_data, input regs_out, wr_onehot, write_count);
  modport slave (input wr_en, wr_addr, wr_data, output regs_out, wr_onehot, write_count);
endinterface

// File: rtl/regfile_write_bank.sv
// regfile_write_bank: decoded, enable-gated write side of the 32x64 register file with hardwired-zero X31
module regfile_write_bank_dff_en (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) q <= rst ? 1'b0 : en ? d : q;
endmodule

module regfile_write_bank_dec2to4 (
  input  logic en,
  input  logic [1:0] a,
  output logic [3:0] y
);
  assign y = en ? 4'b0001 << a : 4'b0000;
endmodule

module regfile_write_bank_dec3to8 (
  input  logic [2:0] a,
  output logic [7:0] y
);
  assign y = 8'b0000_0001 << a;
endmodule

module regfile_write_bank #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32,
  parameter int AW = 5,
  parameter int ZERO_REG = 31
) (
  input logic clk,
  input logic reset,
  regfile_write_bank_if.slave bus
);
  logic [AW-1:0] a;
  logic [3:0] hi;
  logic [7:0] lo;
  logic [NREGS-1:0] raw, onehot;
  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [15:0] cnt;
  assign a = bus.wr_addr;
  // wr_en gates only the upper 2:4 stage; every lower-stage product inherits it
  regfile_write_bank_dec2to4 u_hi (.en(bus.wr_en), .a(a[AW-1:3]), .y(hi));
  regfile_write_bank_dec3to8 u_lo (.a(a[2:0]), .y(lo));
  for (genvar i = 0; i < 4; i++) begin : g_hi
    for (genvar j = 0; j < 8; j++) begin : g_lo
      assign raw[i*8+j] = hi[i] & lo[j];
    end
  end
  assign onehot = raw & ~(NREGS'(1) << ZERO_REG);
  for (genvar k = 0; k < NREGS; k++) begin : g_reg
    if (k == ZERO_REG) begin : g_zero
      assign regs[k] = '0;
    end else begin : g_store
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        regfile_write_bank_dff_en u_dff (
          .clk(clk), .rst(reset), .en(onehot[k]), .d(bus.wr_data[b]), .q(regs[k][b])
        );
      end
    end
  end
  always_ff @(posedge clk)
    cnt <= reset ? 16'd0 : (|onehot && !(&cnt)) ? cnt + 16'd1 : cnt;
  assign bus.regs_out = regs;
  assign bus.wr_onehot = onehot;
  assign bus.write_count = cnt;
endmodule
